// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default bit timing.
// Used by the transmit controller and intended for the receive side as well.
package uart_pkg;

  // 100 MHz system clock at 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts clk cycles within one bit and flags the last cycle.
// A synchronous clear restarts the period; the count also wraps after bit_end.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = (cnt_q == CntMax);
    cnt_d   = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a word, steps the serializer and drives the line.
// Define UART_TX_PARITY_EN to insert a parity bit between the data bits and the stop bit(s).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_valid,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         parallel_data,
  output logic                          serial_enable,
  output logic [$clog2(DATA_WIDTH)-1:0] serial_data_index,
  input  logic                          serial_data,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_WIDTH - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("PARITY_ODD must be 0 or 1");
  end
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("DATA_WIDTH must be at least 2");
  end

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  // Counts data bits in DATA, then stop bits in STOP.
  logic [IdxW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  baud_clear;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    idx_d         = idx_q;
    bit_cnt_d     = bit_cnt_q;
    done_d        = 1'b0;
    serial_enable = 1'b0;
    tx_ready      = 1'b0;
    tx_out        = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          data_d    = tx_data;
          idx_d     = '0;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data ^ PARITY_ODD[0];
`endif
          state_d   = StStart;
        end
      end
      StStart: begin
        tx_out = 1'b0;
        // Strobe on the last start cycle so the serializer holds bit 0 as DATA begins.
        if (bit_end) begin
          serial_enable = 1'b1;
          state_d       = StData;
        end
      end
      StData: begin
        tx_out = serial_data;
        if (bit_end) begin
          if (bit_cnt_q < LastData) begin
            serial_enable = 1'b1;
            bit_cnt_d     = bit_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_out = parity_q;
        if (bit_end) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        tx_out = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == LastStop) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (serial_enable) begin
      idx_d = idx_q + 1'b1;
    end
  end

  assign baud_clear        = (state_d != state_q);
  assign tx_busy           = (state_q != StIdle);
  assign tx_done           = done_q;
  assign parallel_data     = data_q;
  assign serial_data_index = idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      data_q    <= '0;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl at 4 clk per bit, with a behavioural serializer on each instance.
// Instance 1 uses one stop bit, instance 2 uses two; sel routes stimulus and checks.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  logic       ready1, se1, sd1, out1, busy1, done1;
  logic [7:0] pd1;
  logic [2:0] idx1;
  logic       ready2, se2, sd2, out2, busy2, done2;
  logic [7:0] pd2;
  logic [2:0] idx2;

  uart_tx_ctrl #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid & ~sel), .tx_data(tx_data),
    .tx_ready(ready1), .parallel_data(pd1), .serial_enable(se1),
    .serial_data_index(idx1), .serial_data(sd1), .tx_out(out1), .tx_busy(busy1),
    .tx_done(done1)
  );

  uart_tx_ctrl #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)
  ) dut2 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid & sel), .tx_data(tx_data),
    .tx_ready(ready2), .parallel_data(pd2), .serial_enable(se2),
    .serial_data_index(idx2), .serial_data(sd2), .tx_out(out2), .tx_busy(busy2),
    .tx_done(done2)
  );

  // Serializer models: register the selected bit on each load strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sd1 <= 1'b0;
    else if (se1) sd1 <= pd1[idx1];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sd2 <= 1'b0;
    else if (se2) sd2 <= pd2[idx2];
  end

  logic       m_ready, m_se, m_out, m_busy, m_done;
  logic [7:0] m_pd;
  logic [2:0] m_idx;
  assign m_ready = sel ? ready2 : ready1;
  assign m_se    = sel ? se2    : se1;
  assign m_out   = sel ? out2   : out1;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_done  = sel ? done2  : done1;
  assign m_pd    = sel ? pd2    : pd1;
  assign m_idx   = sel ? idx2   : idx1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int se_idx[$];
  always @(negedge clk) if (m_se) se_idx.push_back(int'(m_idx));

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // line[j] = expected level in bit period j (start, d0..d7, stop)
    logic       par;   // even parity of data
  } vec_t;

  vec_t vecs[7];

  task automatic start_send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", 32'(m_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
  endtask

  // Called just after the accept edge; checks every cycle up to and including the tx_done cycle.
  task automatic check_frame(input logic [7:0] d, input logic [9:0] line, input logic par,
                             input int stops, input bit hold, input bit disturb);
    int nper = 9 + PAR + stops;
    int last = nper * CPB + 1;
    logic e;
    se_idx.delete();
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) tx_valid = 1'b0;
      if (disturb && k == 18) begin
        tx_valid = 1'b1;
        tx_data  = ~d;
      end
      if (disturb && k == 19) tx_valid = 1'b0;
      if (k < last) begin
        int j = (k - 1) / CPB;
        if (j <= 8) e = line[j];
        else if (PAR == 1 && j == 9) e = par;
        else e = 1'b1;
        check($sformatf("tx_out d=%0h period=%0d cyc=%0d", d, j, k), 32'(m_out), 32'(e));
        check($sformatf("tx_busy d=%0h cyc=%0d", d, k), 32'(m_busy), 32'd1);
        check($sformatf("tx_done_early d=%0h cyc=%0d", d, k), 32'(m_done), 32'd0);
      end else begin
        check($sformatf("tx_done d=%0h", d), 32'(m_done), 32'd1);
        check($sformatf("tx_ready_at_done d=%0h", d), 32'(m_ready), 32'd1);
        check($sformatf("idle_line d=%0h", d), 32'(m_out), 32'd1);
        check($sformatf("busy_at_done d=%0h", d), 32'(m_busy), 32'd0);
        check($sformatf("parallel_data d=%0h", d), 32'(m_pd), 32'(d));
      end
    end
    check($sformatf("se_count d=%0h", d), 32'(se_idx.size()), 32'd8);
    for (int i = 0; i < se_idx.size() && i < 8; i++) begin
      check($sformatf("se_index d=%0h n=%0d", d, i), 32'(se_idx[i]), 32'(i));
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[2] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[3] = '{8'h80, 10'b1100000000, 1'b1};
    vecs[4] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[5] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[6] = '{8'h5A, 10'b1010110100, 1'b0};

    #23;
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_tx_out", 32'(out1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_se", 32'(se1), 32'd0);
    check("rst_idx", 32'(idx1), 32'd0);
    check("rst_pd", 32'(pd1), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      start_send(vecs[i].data);
      check_frame(vecs[i].data, vecs[i].line, vecs[i].par, 1, 1'b0, i == 2);
    end

    // Back-to-back with tx_valid held: 0x00 then 0xFF.
    start_send(vecs[4].data);
    check_frame(vecs[4].data, vecs[4].line, vecs[4].par, 1, 1'b1, 1'b0);
    tx_data = vecs[5].data;
    @(posedge clk);
    check_frame(vecs[5].data, vecs[5].line, vecs[5].par, 1, 1'b0, 1'b0);

    // Reset during the fourth data bit, then a full frame.
    start_send(vecs[0].data);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_tx_out", 32'(out1), 32'd1);
    check("midrst_ready", 32'(ready1), 32'd1);
    check("midrst_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_send(vecs[6].data);
    check_frame(vecs[6].data, vecs[6].line, vecs[6].par, 1, 1'b0, 1'b0);

    // Two stop bits.
    @(negedge clk);
    sel = 1'b1;
    start_send(vecs[0].data);
    check_frame(vecs[0].data, vecs[0].line, vecs[0].par, 2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
